// File: rtl/demux4_stream_sched_if.sv
// Stream bus for the 1:4 demux scheduler: one input stream, four output lanes.
//
// Handshake rules (input stream and every output lane alike): a word moves
// on a rising clk edge where valid and ready are both 1. A producer holding
// valid=1 keeps its word stable until that edge. ready never depends on the
// same side's valid. Output lanes use bit0=a, bit1=b, bit2=c, bit3=d.
interface demux4_stream_sched_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_sel;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] out_c;
  logic [DATA_W-1:0] out_d;

  // Upstream producer / downstream consumers.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_c, out_d
  );

  // The scheduler itself.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_a, out_b, out_c, out_d
  );
endinterface

// File: rtl/demux4_stream_sched.sv
// 1:4 stream demux scheduler. Words go to the lane picked by in_sel
// (addressed) or by a strict round-robin pointer. Each lane has a one-entry
// holding register. A RUN/DRAIN FSM lets the block stop without losing
// held words.
module demux4_stream_sched #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  demux4_stream_sched_if.slave bus,
  output logic [1:0]           rr_ptr,
  output logic                 busy,
  output logic [CNT_W-1:0]     acc_cnt,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t                   state_q, state_d;
  logic                     mode_q, mode_d;
  logic [1:0]               rr_q, rr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [3:0]               valid_q, valid_d;
  logic [3:0][DATA_W-1:0]   data_q, data_d;

  logic [1:0]               tgt;
  logic                     in_ready;
  logic                     accept;

  // Target lane and input handshake; in_ready never looks at in_valid.
  assign tgt      = mode_q ? rr_q : bus.in_sel;
  assign in_ready = (state_q == RUN) && en &&
                    (!valid_q[tgt] || bus.out_ready[tgt]);
  assign accept   = bus.in_valid && in_ready;

  // FSM next state; mode is latched and the pointer reset only on IDLE->RUN.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          mode_d  = mode;
        end
      end
      RUN: begin
        if (!en) state_d = DRAIN;
      end
      DRAIN: begin
        if (valid_q == 4'b0000) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane registers, round-robin pointer and accept counter.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    // Each lane drains independently when its consumer takes the word.
    for (int i = 0; i < 4; i++) begin
      if (valid_q[i] && bus.out_ready[i]) valid_d[i] = 1'b0;
    end
    // A load wins over a same-cycle drain, so a lane can stream every cycle.
    if (accept) begin
      valid_d[tgt] = 1'b1;
      data_d[tgt]  = bus.in_data;
      cnt_d        = cnt_q + CNT_W'(1);
      if (mode_q) rr_d = rr_q + 2'd1;
    end
    if (state_q == IDLE && en) rr_d = 2'd0;
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      rr_q    <= 2'd0;
      cnt_q   <= '0;
      valid_q <= 4'b0000;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_a     = data_q[0];
  assign bus.out_b     = data_q[1];
  assign bus.out_c     = data_q[2];
  assign bus.out_d     = data_q[3];
  assign rr_ptr        = rr_q;
  assign busy          = (state_q != IDLE);
  assign acc_cnt       = cnt_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_demux4_stream_sched.sv
// Bench for demux4_stream_sched: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the scheduler rules.
module tb_demux4_stream_sched;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic mode;
  always #5 clk = ~clk;

  logic [1:0]       rr_ptr, rr_ptr4, state_dbg, state_dbg4;
  logic             busy, busy4;
  logic [CNT_W-1:0] acc_cnt;
  logic [3:0]       acc_cnt4;

  int checks = 0;
  int errors = 0;

  demux4_stream_sched_if #(.DATA_W(DATA_W)) ifc ();
  demux4_stream_sched_if #(.DATA_W(DATA_W)) if4 ();

  // Narrow-counter copy sees the same input traffic.
  assign if4.in_valid  = ifc.in_valid;
  assign if4.in_data   = ifc.in_data;
  assign if4.in_sel    = ifc.in_sel;
  assign if4.out_ready = ifc.out_ready;

  demux4_stream_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .bus(ifc),
    .rr_ptr(rr_ptr), .busy(busy), .acc_cnt(acc_cnt), .state_dbg(state_dbg)
  );

  demux4_stream_sched #(.DATA_W(DATA_W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .bus(if4),
    .rr_ptr(rr_ptr4), .busy(busy4), .acc_cnt(acc_cnt4), .state_dbg(state_dbg4)
  );

  // ---------------- reference model ----------------
  int                m_state;     // 0 idle, 1 run, 2 drain
  bit                m_mode;
  int                m_rr;
  bit                m_valid[4];
  logic [DATA_W-1:0] m_data[4];
  int unsigned       m_cnt;
  logic [DATA_W-1:0] exp_q[$];    // words expected to leave, lane order per cycle

  function automatic void model_reset();
    m_state = 0; m_mode = 0; m_rr = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_data[i] = '0; end
    exp_q.delete();
  endfunction

  function automatic int model_tgt();
    return m_mode ? m_rr : int'(ifc.in_sel);
  endfunction

  function automatic bit model_ready();
    int t = model_tgt();
    return (m_state == 1) && en && (!m_valid[t] || ifc.out_ready[t]);
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_valid[i];
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_clock();
    int t = model_tgt();
    bit acc = ifc.in_valid && model_ready();
    bit any = m_valid[0] | m_valid[1] | m_valid[2] | m_valid[3];
    for (int i = 0; i < 4; i++) if (m_valid[i] && ifc.out_ready[i]) m_valid[i] = 0;
    if (acc) begin
      m_valid[t] = 1; m_data[t] = ifc.in_data; m_cnt++;
      if (m_mode) m_rr = (m_rr + 1) % 4;
    end
    case (m_state)
      0: if (en) begin m_state = 1; m_mode = mode; m_rr = 0; end
      1: if (!en) m_state = 2;
      default: if (!any) m_state = 0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] dut_lane(input int i);
    case (i)
      0: return ifc.out_a;
      1: return ifc.out_b;
      2: return ifc.out_c;
      default: return ifc.out_d;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [DATA_W-1:0] d,
                       input logic [1:0] s, input logic [3:0] r);
    ifc.in_valid = v; ifc.in_data = d; ifc.in_sel = s; ifc.out_ready = r;
    #1;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic tick();
    model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    en = 0; mode = 0;
    drive(0, '0, 2'd0, 4'b0000);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    en = 0; mode = 0; rst_n = 1'b0;
    drive(0, '0, 2'd0, 4'b0000);
    model_reset();
    @(negedge clk);
    checks++; if (ifc.out_valid !== 4'b0000) begin errors++; $display("FAIL reset out_valid got %b exp 0000", ifc.out_valid); end
    checks++; if ({ifc.out_a, ifc.out_b, ifc.out_c, ifc.out_d} !== 32'h0) begin errors++; $display("FAIL reset lanes got %h exp 0", {ifc.out_a, ifc.out_b, ifc.out_c, ifc.out_d}); end
    checks++; if (rr_ptr !== 2'd0 || busy !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL reset status rr=%0d busy=%b st=%0d exp 0/0/0", rr_ptr, busy, state_dbg); end
    checks++; if (acc_cnt !== '0 || ifc.in_ready !== 1'b0) begin errors++; $display("FAIL reset cnt=%0d rdy=%b exp 0/0", acc_cnt, ifc.in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addressed();
    logic [DATA_W-1:0] words[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_reset();
    en = 1; mode = 0;
    tick();
    checks++; if (state_dbg !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL addr enter_run st=%0d busy=%b exp 1/1", state_dbg, busy); end
    for (int k = 0; k < 4; k++) begin
      drive(1, words[k], 2'(k), 4'b1111);
      checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL addr in_ready[%0d] got %b exp 1", k, ifc.in_ready); end
      tick();
      checks++; if (ifc.out_valid !== 4'(1 << k) || dut_lane(k) !== words[k]) begin
        errors++; $display("FAIL addr lane%0d valid=%b data=%h exp %b/%h", k, ifc.out_valid, dut_lane(k), 4'(1 << k), words[k]);
      end
    end
    checks++; if (acc_cnt !== 16'd4) begin errors++; $display("FAIL addr acc_cnt got %0d exp 4", acc_cnt); end
  endtask

  task automatic test_rr_backpressure();
    do_reset();
    en = 1; mode = 1;
    drive(0, '0, 2'd0, 4'b0000);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 8'(8'h11 + k), 2'd0, 4'b0000);
      checks++; if (ifc.in_ready !== 1'b1 || rr_ptr !== 2'(k)) begin errors++; $display("FAIL rr accept%0d rdy=%b rr=%0d exp 1/%0d", k, ifc.in_ready, rr_ptr, k); end
      tick();
    end
    checks++; if (ifc.out_valid !== 4'b1111 || rr_ptr !== 2'd0) begin errors++; $display("FAIL rr full valid=%b rr=%0d exp 1111/0", ifc.out_valid, rr_ptr); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dut_lane(i) !== 8'(8'h11 + i)) begin errors++; $display("FAIL rr lane%0d got %h exp %h", i, dut_lane(i), 8'(8'h11 + i)); end
    end
    drive(1, 8'h15, 2'd2, 4'b0000);
    checks++; if (ifc.in_ready !== 1'b0) begin errors++; $display("FAIL rr stall in_ready got %b exp 0", ifc.in_ready); end
    tick();
    checks++; if (ifc.out_a !== 8'h11 || acc_cnt !== 16'd4 || rr_ptr !== 2'd0) begin errors++; $display("FAIL rr hold a=%h cnt=%0d rr=%0d exp 11/4/0", ifc.out_a, acc_cnt, rr_ptr); end
    drive(1, 8'h15, 2'd2, 4'b0001);
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL rr release in_ready got %b exp 1", ifc.in_ready); end
    tick();
    checks++; if (ifc.out_a !== 8'h15 || ifc.out_valid !== 4'b1111 || rr_ptr !== 2'd1 || acc_cnt !== 16'd5) begin
      errors++; $display("FAIL rr reload a=%h valid=%b rr=%0d cnt=%0d exp 15/1111/1/5", ifc.out_a, ifc.out_valid, rr_ptr, acc_cnt);
    end
  endtask

  task automatic test_reload();
    do_reset();
    en = 1; mode = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 8'(8'h20 + k), 2'd2, 4'b0100);
      checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reload in_ready[%0d] got %b exp 1", k, ifc.in_ready); end
      tick();
      checks++; if (ifc.out_valid !== 4'b0100 || ifc.out_c !== 8'(8'h20 + k)) begin
        errors++; $display("FAIL reload c[%0d] valid=%b data=%h exp 0100/%h", k, ifc.out_valid, ifc.out_c, 8'(8'h20 + k));
      end
    end
    drive(0, '0, 2'd2, 4'b0100);
    tick();
    checks++; if (ifc.out_valid !== 4'b0000) begin errors++; $display("FAIL reload empty valid got %b exp 0000", ifc.out_valid); end
  endtask

  task automatic test_drain();
    do_reset();
    en = 1; mode = 0;
    tick();
    drive(1, 8'hB0, 2'd1, 4'b0000); tick();
    drive(1, 8'hD0, 2'd3, 4'b0000); tick();
    checks++; if (ifc.out_valid !== 4'b1010) begin errors++; $display("FAIL drain fill valid got %b exp 1010", ifc.out_valid); end
    en = 0;
    drive(1, 8'hEE, 2'd0, 4'b0000);
    checks++; if (ifc.in_ready !== 1'b0) begin errors++; $display("FAIL drain en_low in_ready got %b exp 0", ifc.in_ready); end
    tick();
    checks++; if (state_dbg !== 2'd2 || busy !== 1'b1 || acc_cnt !== 16'd2) begin errors++; $display("FAIL drain enter st=%0d busy=%b cnt=%0d exp 2/1/2", state_dbg, busy, acc_cnt); end
    en = 1;
    drive(1, 8'hEE, 2'd0, 4'b0000);
    checks++; if (ifc.in_ready !== 1'b0) begin errors++; $display("FAIL drain en_ignored in_ready got %b exp 0", ifc.in_ready); end
    tick();
    drive(0, '0, 2'd0, 4'b0010); tick();
    checks++; if (ifc.out_valid !== 4'b1000 || state_dbg !== 2'd2) begin errors++; $display("FAIL drain b valid=%b st=%0d exp 1000/2", ifc.out_valid, state_dbg); end
    drive(0, '0, 2'd0, 4'b1000); tick();
    checks++; if (ifc.out_valid !== 4'b0000 || state_dbg !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL drain d valid=%b st=%0d busy=%b exp 0000/2/1", ifc.out_valid, state_dbg, busy); end
    tick();
    checks++; if (state_dbg !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL drain idle st=%0d busy=%b exp 0/0", state_dbg, busy); end
  endtask

  task automatic test_mode_latch();
    do_reset();
    en = 1; mode = 0;
    tick();
    mode = 1;
    drive(1, 8'h5A, 2'd3, 4'b0000);
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL mode in_ready got %b exp 1", ifc.in_ready); end
    tick();
    checks++; if (ifc.out_valid !== 4'b1000 || ifc.out_d !== 8'h5A || rr_ptr !== 2'd0) begin errors++; $display("FAIL mode route valid=%b d=%h rr=%0d exp 1000/5a/0", ifc.out_valid, ifc.out_d, rr_ptr); end
    drive(1, 8'h6B, 2'd1, 4'b0000); tick();
    checks++; if (ifc.out_valid !== 4'b1010 || ifc.out_b !== 8'h6B || rr_ptr !== 2'd0) begin errors++; $display("FAIL mode route2 valid=%b b=%h rr=%0d exp 1010/6b/0", ifc.out_valid, ifc.out_b, rr_ptr); end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    en = 1; mode = 0;
    tick();
    for (int k = 0; k < 17; k++) begin
      drive(1, 8'(k), 2'(k % 4), 4'b1111);
      tick();
    end
    checks++; if (acc_cnt4 !== 4'd1) begin errors++; $display("FAIL wrap acc_cnt4 got %0d exp 1", acc_cnt4); end
    checks++; if (acc_cnt !== 16'd17) begin errors++; $display("FAIL wrap acc_cnt got %0d exp 17", acc_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1; mode = 0;
    tick();
    drive(1, 8'h0A, 2'd0, 4'b0000); tick();
    drive(1, 8'h0C, 2'd2, 4'b0000); tick();
    drive(1, 8'h0B, 2'd1, 4'b0000);
    checks++; if (ifc.out_valid !== 4'b0101 || ifc.in_ready !== 1'b1) begin errors++; $display("FAIL areset pre valid=%b rdy=%b exp 0101/1", ifc.out_valid, ifc.in_ready); end
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (ifc.out_valid !== 4'b0000 || ifc.in_ready !== 1'b0) begin errors++; $display("FAIL areset valid=%b rdy=%b exp 0000/0", ifc.out_valid, ifc.in_ready); end
    checks++; if ({ifc.out_a, ifc.out_b, ifc.out_c, ifc.out_d} !== 32'h0 || rr_ptr !== 2'd0 || busy !== 1'b0 || acc_cnt !== '0) begin
      errors++; $display("FAIL areset regs lanes=%h rr=%0d busy=%b cnt=%0d exp 0/0/0/0", {ifc.out_a, ifc.out_b, ifc.out_c, ifc.out_d}, rr_ptr, busy, acc_cnt);
    end
    en = 0;
    drive(0, '0, 2'd0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] got;
    bit exp_r;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      en   = ($urandom_range(0, 11) != 0);
      mode = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      exp_r = model_ready();
      checks++; if (ifc.in_ready !== exp_r) begin errors++; $display("FAIL rand in_ready cyc%0d got %b exp %b", n, ifc.in_ready, exp_r); end
      for (int i = 0; i < 4; i++) if (m_valid[i] && ifc.out_ready[i]) exp_q.push_back(m_data[i]);
      for (int i = 0; i < 4; i++) begin
        if (ifc.out_valid[i] && ifc.out_ready[i]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL rand extra_word cyc%0d lane%0d got %h exp none", n, i, dut_lane(i));
          end else begin
            got = exp_q.pop_front();
            if (dut_lane(i) !== got) begin errors++; $display("FAIL rand deliver cyc%0d lane%0d got %h exp %h", n, i, dut_lane(i), got); end
          end
        end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand missing_word cyc%0d got 0 exp %0d", n, exp_q.size()); exp_q.delete(); end
      tick();
      checks++; if (ifc.out_valid !== model_valid()) begin errors++; $display("FAIL rand out_valid cyc%0d got %b exp %b", n, ifc.out_valid, model_valid()); end
      checks++; if (rr_ptr !== 2'(m_rr) || busy !== (m_state != 0) || state_dbg !== 2'(m_state)) begin
        errors++; $display("FAIL rand status cyc%0d rr=%0d busy=%b st=%0d exp %0d/%b/%0d", n, rr_ptr, busy, state_dbg, m_rr, (m_state != 0), m_state);
      end
      checks++; if (acc_cnt !== m_cnt[15:0] || acc_cnt4 !== m_cnt[3:0]) begin
        errors++; $display("FAIL rand acc_cnt cyc%0d got %0d/%0d exp %0d/%0d", n, acc_cnt, acc_cnt4, m_cnt[15:0], m_cnt[3:0]);
      end
      for (int i = 0; i < 4; i++) begin
        if (m_valid[i]) begin
          checks++; if (dut_lane(i) !== m_data[i]) begin errors++; $display("FAIL rand lane%0d cyc%0d got %h exp %h", i, n, dut_lane(i), m_data[i]); end
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_addressed();
    test_rr_backpressure();
    test_reload();
    test_drain();
    test_mode_latch();
    test_cnt_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux4_stream_sched.md
Name: demux4_stream_sched

Overview:
- Scheduler and controller for a 1:4 demux datapath.
- Accepts a valid/ready input stream and steers each word to one of four outputs, a/b/c/d.
- Destination comes either from a per-word select (addressed mode) or from an internal round-robin pointer.
- Each output has a one-entry holding register with its own valid/ready handshake.
- A run/drain state machine allows clean enable/disable without losing words.

Parameters:
DATA_W, 8, width of data words
CNT_W, 16, width of accepted-word counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable
mode  input  1  0 = addressed (in_sel), 1 = round-robin
in_valid  input  1  input word valid
in_ready  output  1  scheduler can accept a word this cycle
in_data  input  DATA_W  input word
in_sel  input  2  destination in addressed mode (00=a, 01=b, 10=c, 11=d)
out_valid  output  4  per-output valid; bit0=a, bit1=b, bit2=c, bit3=d
out_ready  input  4  per-output ready, same bit mapping
out_a  output  DATA_W  holding register a
out_b  output  DATA_W  holding register b
out_c  output  DATA_W  holding register c
out_d  output  DATA_W  holding register d
rr_ptr  output  2  current round-robin target
busy  output  1  high when state is not IDLE
acc_cnt  output  CNT_W  total accepted words

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - rst_n low asynchronously forces: state=IDLE, out_valid=0000, out_a..out_d=0, rr_ptr=0, mode_q=0, acc_cnt=0.
  - Reset mid-transfer discards all held words.
- States (encoding IDLE=00, RUN=01, DRAIN=10; 11 is unreachable and recovers to IDLE):
  - IDLE: in_ready=0. On en=1, go to RUN; latch mode into mode_q; clear rr_ptr to 0.
  - RUN: accepts words. On en=0, go to DRAIN; no accept occurs in the cycle en is sampled low.
  - DRAIN: in_ready=0; en is ignored. When out_valid==0000 (registered value), go to IDLE.
- Target selection: t = mode_q ? rr_ptr : in_sel. mode changes outside IDLE have no effect until the next IDLE->RUN.
- Input handshake:
  - in_ready = (state==RUN) && en && (!out_valid[t] || out_ready[t]).
  - in_ready is combinational from state, en, mode_q, rr_ptr, in_sel, out_valid, out_ready. It never depends on in_valid.
  - Accept = in_valid && in_ready.
  - On accept: register t loads in_data; out_valid[t]=1 next cycle (latency 1 clock). acc_cnt increments by 1, wrapping modulo 2^CNT_W.
  - Accept into a register being drained the same cycle is allowed: the new word replaces it and out_valid stays 1 (full throughput per lane).
- Output handshake:
  - When out_valid[i]=1 and out_ready[i]=0, register i and out_valid[i] hold stable.
  - When out_valid[i]=1, out_ready[i]=1 and there is no same-cycle reload, out_valid[i] clears next cycle. Data value is don't-care but held.
  - out_ready on an invalid lane has no effect.
- Round-robin:
  - rr_ptr advances +1 (3 wraps to 0) on each accept, only when mode_q=1.
  - If the target lane is full and not draining, in_ready=0 and rr_ptr holds; there is no skipping to another lane (strict order).
  - In mode_q=0, rr_ptr holds.
- Simultaneous events:
  - Lanes drain independently; multiple lanes may handshake in one cycle.
  - en falling while in_valid=1 means that word is not accepted.
- busy = (state != IDLE).

Test Plan:
- Reset and idle: assert rst_n=0 mid-run with out_valid=0101 -> all outputs 0, rr_ptr=0, busy=0, in_ready=0 immediately, without a clock edge.
- Addressed mode: en=1, mode=0, out_ready=1111, in_data=A1/B2/C3/D4 with in_sel=00/01/10/11 on consecutive cycles -> out_a=A1 one cycle after its accept, then B2/C3/D4 on lanes b/c/d each one cycle later; acc_cnt=4.
- Round-robin backpressure: mode=1, out_ready=0000, send 5 words 11..15 -> first 4 accepted into a..d with rr_ptr back to 0 and in_ready=0; raise out_ready[0] -> 15 accepted into a after 11 is taken.
- Same-cycle reload: mode=0, in_sel=10, out_ready[2]=1, stream 20,21,22 back-to-back -> in_ready held 1, out_valid[2] stays 1, out_c shows 20,21,22 on successive cycles.
- Drain: lanes b and d full with out_ready=0, drop en -> state DRAIN, in_ready=0, busy=1; release out_ready[1], then out_ready[3] -> IDLE the cycle after out_valid reads 0000, busy=0.
- Mode latch and counter wrap: toggle mode during RUN -> routing unchanged; CNT_W=4 build, 17 accepts -> acc_cnt=1.
